regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's NUM_WPORTS write ports among NUM_SRC writeback sources (ALU, LSU, MUL/DIV, CSR).
//  Round-robin grant with valid/ready handshake per source; same-cycle same-rd hazards resolved in scan order.
//  Grants are registered, so the write reaches the register file one cycle after the handshake.
//  Drives the regfile rd_wen/addr_rd/rd_data port arrays.
// PARAMETERS
//  NUM_SRC     4   number of writeback requesters (>=2)
//  NUM_WPORTS  2   register file write ports (1..NUM_SRC)
//  NUM_REGS    32  architectural registers; address width NUM_REGS_WIDTH = $clog2(NUM_REGS)
//  REG_WIDTH   32  data width
// PORTS
//  clk        in   1                           clock, all state on posedge
//  rst        in   1                           synchronous, active-high reset
//  src_valid  in   [NUM_SRC]                   source k holds a writeback
//  src_rd     in   [NUM_SRC] x NUM_REGS_WIDTH  destination register of source k
//  src_data   in   [NUM_SRC] x REG_WIDTH       result of source k
//  src_ready  out  [NUM_SRC]                   combinational; valid&ready = writeback accepted this cycle
//  wport_wen  out  [NUM_WPORTS]                registered write enable to regfile rd_wen
//  wport_addr out  [NUM_WPORTS] x NUM_REGS_WIDTH  registered regfile addr_rd
//  wport_data out  [NUM_WPORTS] x REG_WIDTH    registered regfile rd_data
// BEHAVIOUR
//  - State: rr_ptr (clog2(NUM_SRC) bits), output registers. Reset: rr_ptr=0, wport_wen=0, addr=0, data=0.
//  - src_ready forced 0 while rst=1; reset mid-burst discards nothing already registered before rst, drops pending grants.
//  - Each cycle scan sources rr_ptr, rr_ptr+1, ... mod NUM_SRC. Valid source k is granted when:
//    (a) src_rd[k]==0: always granted, consumes no port (x0 writes discarded);
//    (b) else a port is free AND no earlier-granted source this cycle has the same src_rd -> gets next free port.
//  - Port assignment: n-th port-consuming grant in scan order -> port n; unused ports wen=0 next cycle.
//  - Same-rd conflict: later source in scan order not granted, even with ports free; retried next cycle.
//  - Granted source sees src_ready=1 same cycle; ungranted valid sources see 0 and must hold rd/data stable.
//  - Next cycle: wport_wen[n]=1, wport_addr[n]/wport_data[n] = granted values. Latency exactly 1 cycle.
//  - rr_ptr update: (index of last granted source incl. x0 grants)+1 mod NUM_SRC; unchanged if no grant.
//    Guarantees any valid source is granted within ceil(NUM_SRC/NUM_WPORTS)+1 cycles barring same-rd stalls.
//  - Writes to the same rd across consecutive cycles reach the regfile in grant order.
//  - src_ready depends only on src_valid, src_rd and rr_ptr; never on src_data.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: adds outputs byp_valid[NUM_WPORTS], byp_addr, byp_data = combinational copy of
//   this cycle's port grants (same values wport_* show next cycle), for operand forwarding one cycle early.
//  RF_WB_BYPASS_EN undefined: byp_* ports absent; all other behaviour identical.
// TESTING (NUM_SRC=4, NUM_WPORTS=2)
//  1. rst=1 for 2 cycles, all src_valid=1 -> src_ready=0000, wport_wen=00; first cycle after: src0,src1 granted.
//  2. All valid, rd=1,2,3,4 held -> wen=11 addr{1,2}, then {3,4}, then {1,2}; rr_ptr cycles 0,2,0.
//  3. rr_ptr=0, src0 rd=0, src1 rd=5, src2 rd=6 -> ready=0111, next cycle wen=11 addr{5,6}; src0 never written.
//  4. rr_ptr=1, src1 and src2 rd=7, src3 rd=9 -> ready=1010, ports {7,9}; next cycle src2 granted to rd 7 on port0.
//  5. Only src3 valid 3 cycles, data 0xA,0xB,0xC, rd=4 -> port0 writes 0xA,0xB,0xC back-to-back, 1-cycle latency.
//  6. RF_WB_BYPASS_EN: scenario 2 -> byp_addr{1,2} same cycle as grant, equals wport_addr next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that maps NUM_SRC writeback sources onto NUM_WPORTS registered regfile write ports.
// Optional RF_WB_BYPASS_EN exposes this cycle's port grants combinationally for early operand forwarding.
module regfile_wb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_WPORTS = 2,
  parameter int NUM_REGS   = 32,
  parameter int REG_WIDTH  = 32,
  localparam int NUM_REGS_WIDTH = $clog2(NUM_REGS),
  localparam int PTR_W          = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_REGS_WIDTH-1:0] src_rd     [NUM_SRC],
  input  logic [REG_WIDTH-1:0]      src_data   [NUM_SRC],
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [NUM_WPORTS-1:0]     wport_wen,
  output logic [NUM_REGS_WIDTH-1:0] wport_addr [NUM_WPORTS],
  output logic [REG_WIDTH-1:0]      wport_data [NUM_WPORTS]
`ifdef RF_WB_BYPASS_EN
  ,
  output logic [NUM_WPORTS-1:0]     byp_valid,
  output logic [NUM_REGS_WIDTH-1:0] byp_addr   [NUM_WPORTS],
  output logic [REG_WIDTH-1:0]      byp_data   [NUM_WPORTS]
`endif
);

  // Handshake: a source's write is accepted in the cycle where src_valid[k] & src_ready[k];
  // an unaccepted source keeps src_valid high and holds src_rd/src_data stable.

  logic [PTR_W-1:0]          rr_ptr;
  logic [NUM_SRC-1:0]        grant;
  logic [NUM_WPORTS-1:0]     nxt_wen;
  logic [NUM_REGS_WIDTH-1:0] nxt_addr [NUM_WPORTS];
  logic [REG_WIDTH-1:0]      nxt_data [NUM_WPORTS];
  logic [PTR_W-1:0]          idx;
  logic [PTR_W-1:0]          last_idx;
  logic                      any_grant;
  logic                      conflict;
  int                        port_cnt;

  // Scan from rr_ptr; x0 writes are acknowledged without using a port, and a repeated rd
  // later in the scan waits so the earlier source's write lands first.
  always_comb begin
    grant     = '0;
    nxt_wen   = '0;
    idx       = '0;
    last_idx  = rr_ptr;
    any_grant = 1'b0;
    conflict  = 1'b0;
    port_cnt  = 0;
    for (int n = 0; n < NUM_WPORTS; n++) begin
      nxt_addr[n] = '0;
      nxt_data[n] = '0;
    end
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        idx = PTR_W'((int'(rr_ptr) + i) % NUM_SRC);
        if (src_valid[idx]) begin
          if (src_rd[idx] == '0) begin
            grant[idx] = 1'b1;
            any_grant  = 1'b1;
            last_idx   = idx;
          end else begin
            conflict = 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
              if (grant[k] && (src_rd[k] == src_rd[idx])) conflict = 1'b1;
            end
            if (!conflict && (port_cnt < NUM_WPORTS)) begin
              for (int n = 0; n < NUM_WPORTS; n++) begin
                if (n == port_cnt) begin
                  nxt_wen[n]  = 1'b1;
                  nxt_addr[n] = src_rd[idx];
                  nxt_data[n] = src_data[idx];
                end
              end
              port_cnt   = port_cnt + 1;
              grant[idx] = 1'b1;
              any_grant  = 1'b1;
              last_idx   = idx;
            end
          end
        end
      end
    end
  end

  assign src_ready = grant;

`ifdef RF_WB_BYPASS_EN
  assign byp_valid = nxt_wen;
  assign byp_addr  = nxt_addr;
  assign byp_data  = nxt_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      wport_wen <= '0;
      for (int n = 0; n < NUM_WPORTS; n++) begin
        wport_addr[n] <= '0;
        wport_data[n] <= '0;
      end
    end else begin
      wport_wen <= nxt_wen;
      for (int n = 0; n < NUM_WPORTS; n++) begin
        wport_addr[n] <= nxt_addr[n];
        wport_data[n] <= nxt_data[n];
      end
      if (any_grant) rr_ptr <= PTR_W'((int'(last_idx) + 1) % NUM_SRC);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (4 sources, 2 ports) with a tagged expected-write queue.
module tb_regfile_wb_arbiter;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int EW = 2 + 2 * (RW + DW);

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    src_valid;
  logic [RW-1:0] src_rd     [4];
  logic [DW-1:0] src_data   [4];
  logic [3:0]    src_ready;
  logic [1:0]    wport_wen;
  logic [RW-1:0] wport_addr [2];
  logic [DW-1:0] wport_data [2];
`ifdef RF_WB_BYPASS_EN
  logic [1:0]    byp_valid;
  logic [RW-1:0] byp_addr   [2];
  logic [DW-1:0] byp_data   [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  int            exp_t[$];

  regfile_wb_arbiter #(.NUM_SRC(4), .NUM_WPORTS(2), .NUM_REGS(32), .REG_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data),
    .src_ready(src_ready), .wport_wen(wport_wen), .wport_addr(wport_addr), .wport_data(wport_data)
`ifdef RF_WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // monitor: each expected write is due exactly one cycle after its grant
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [1:0]    ew;
    if (exp_q.size() > 0 && exp_t[0] == cyc) begin
      e  = exp_q.pop_front();
      void'(exp_t.pop_front());
      ew = e[EW-1 -: 2];
      checks++;
      if (wport_wen !== ew) begin
        errors++;
        $display("FAIL wport_wen cyc=%0d got=%b exp=%b", cyc, wport_wen, ew);
      end
      if (ew[0]) begin
        checks++;
        if (wport_addr[0] !== e[73:69] || wport_data[0] !== e[68:37]) begin
          errors++;
          $display("FAIL port0 cyc=%0d got=%0d/%h exp=%0d/%h", cyc, wport_addr[0], wport_data[0], e[73:69], e[68:37]);
        end
      end
      if (ew[1]) begin
        checks++;
        if (wport_addr[1] !== e[36:32] || wport_data[1] !== e[31:0]) begin
          errors++;
          $display("FAIL port1 cyc=%0d got=%0d/%h exp=%0d/%h", cyc, wport_addr[1], wport_data[1], e[36:32], e[31:0]);
        end
      end
    end else if (!rst && wport_wen != 2'b00) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write cyc=%0d wen=%b", cyc, wport_wen);
    end
  end

  // driver tasks
  task automatic set_src(input int k, input logic [RW-1:0] rd, input logic [DW-1:0] data);
    src_rd[k]   = rd;
    src_data[k] = data;
  endtask

  task automatic cycle(input logic [3:0] v, input logic [3:0] exp_rdy, input logic [1:0] ew,
                       input logic [RW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [RW-1:0] a1, input logic [DW-1:0] d1, input int exp_ptr);
    src_valid = v;
    @(negedge clk);
    checks++;
    if (src_ready !== exp_rdy) begin
      errors++;
      $display("FAIL src_ready cyc=%0d got=%b exp=%b", cyc, src_ready, exp_rdy);
    end
    checks++;
    if (int'(dut.rr_ptr) != exp_ptr) begin
      errors++;
      $display("FAIL rr_ptr cyc=%0d got=%0d exp=%0d", cyc, dut.rr_ptr, exp_ptr);
    end
`ifdef RF_WB_BYPASS_EN
    checks++;
    if (byp_valid !== ew || (ew[0] && (byp_addr[0] !== a0 || byp_data[0] !== d0)) ||
        (ew[1] && (byp_addr[1] !== a1 || byp_data[1] !== d1))) begin
      errors++;
      $display("FAIL bypass cyc=%0d got=%b %0d %0d exp=%b %0d %0d", cyc, byp_valid, byp_addr[0], byp_addr[1], ew, a0, a1);
    end
`endif
    if (ew != 2'b00) begin
      exp_q.push_back({ew, a0, d0, a1, d1});
      exp_t.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    src_valid = 4'b1111;
    for (int k = 0; k < 4; k++) set_src(k, RW'(k + 1), DW'(32'h100 + k));
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0000", src_ready);
    end
    checks++;
    if (wport_wen !== 2'b00) begin
      errors++;
      $display("FAIL reset_wen got=%b exp=00", wport_wen);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // all four valid with distinct rd: two grants per cycle, pointer alternates
    cycle(4'b1111, 4'b0011, 2'b11, 1, 32'h100, 2, 32'h101, 0);
    cycle(4'b1111, 4'b1100, 2'b11, 3, 32'h102, 4, 32'h103, 2);
    cycle(4'b1111, 4'b0011, 2'b11, 1, 32'h100, 2, 32'h101, 0);
    cycle(4'b1111, 4'b1100, 2'b11, 3, 32'h102, 4, 32'h103, 2);

    // x0 write acknowledged without a port
    set_src(0, 0, 32'h300);
    set_src(1, 5, 32'h301);
    set_src(2, 6, 32'h302);
    cycle(4'b0111, 4'b0111, 2'b11, 5, 32'h301, 6, 32'h302, 0);

    // wrap-around single grant moves pointer to 1
    set_src(0, 10, 32'h400);
    cycle(4'b0001, 4'b0001, 2'b01, 10, 32'h400, 0, 0, 3);

    // same-rd hazard: src2 waits behind src1 even though a port is free
    set_src(1, 7, 32'h501);
    set_src(2, 7, 32'h502);
    set_src(3, 9, 32'h503);
    cycle(4'b1110, 4'b1010, 2'b11, 7, 32'h501, 9, 32'h503, 1);
    cycle(4'b0100, 4'b0100, 2'b01, 7, 32'h502, 0, 0, 0);

    // single source back-to-back
    set_src(3, 4, 32'hA);
    cycle(4'b1000, 4'b1000, 2'b01, 4, 32'hA, 0, 0, 3);
    set_src(3, 4, 32'hB);
    cycle(4'b1000, 4'b1000, 2'b01, 4, 32'hB, 0, 0, 0);
    set_src(3, 4, 32'hC);
    cycle(4'b1000, 4'b1000, 2'b01, 4, 32'hC, 0, 0, 0);

    // every source targets rd 8: one grant per cycle, writes in grant order
    for (int k = 0; k < 4; k++) set_src(k, 8, DW'(32'h600 + k));
    cycle(4'b1111, 4'b0001, 2'b01, 8, 32'h600, 0, 0, 0);
    cycle(4'b1110, 4'b0010, 2'b01, 8, 32'h601, 0, 0, 1);
    cycle(4'b1100, 4'b0100, 2'b01, 8, 32'h602, 0, 0, 2);
    cycle(4'b1000, 4'b1000, 2'b01, 8, 32'h603, 0, 0, 3);

    // idle: no grants, pointer holds
    cycle(4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    cycle(4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
